// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks: the controller
// state type and the default operand width.
// -----------------------------------------------------------------------------
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Explicit encodings keep the state register readable in waveforms and
    // stable across tool versions.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor computing a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   diff : difference bit
//   bout : borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow
    // is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: accepts a/b with a valid/ready handshake,
// processes one bit per cycle LSB first, and presents (a - b) mod 2^WIDTH
// plus the final borrow with a second valid/ready handshake.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : a/b valid
//   in_ready  : operands accepted this cycle (high in IDLE)
//   a, b      : minuend / subtrahend, unsigned, WIDTH bits
//   out_valid : diff/bout hold a completed result (high in DONE)
//   out_ready : consumer accepts the result
//   diff      : difference, WIDTH bits
//   bout      : final borrow, 1 iff a < b
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit;
    logic               br_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (d_bit),
        .bout (br_bit)
    );

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves state_next unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)            state_next = RUN;
            RUN:     if (cnt == LAST)         state_next = DONE;
            DONE:    if (out_ready)           state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            diff  <= '0;
            bout  <= 1'b0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    // Result fills from the top; after WIDTH shifts bit 0
                    // holds the first (LSB) difference bit.
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    br   <= br_bit;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bout <= br_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand shift registers are left out of reset on purpose:
    // they are always reloaded before use, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_sr <= a;
            b_sr <= b;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor: a WIDTH=8 instance for directed
// and randomized handshake scenarios, and a WIDTH=4 instance for an
// exhaustive back-to-back sweep against an arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst8, in_valid8, in_ready8, out_valid8, out_ready8, bout8;
    logic [7:0] a8, b8, diff8;
    // WIDTH=4 instance
    logic       rst4, in_valid4, in_ready4, out_valid4, out_ready4, bout4;
    logic [3:0] a4, b4, diff4;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete 8-bit operation with latency, hold, handoff and retain
    // checks. Expected values come from plain integer arithmetic.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           input int hold, input bit scramble);
        int         n;
        logic [7:0] exp_d;
        logic       exp_b;
        exp_d = 8'((int'(av) - int'(bv) + 256) % 256);
        exp_b = (int'(av) < int'(bv));
        n = 0;
        while (!in_ready8 && n < 50) begin tick(); n++; end
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout in_ready=%b required 1", in_ready8);
            return;
        end
        in_valid8 = 1'b1; a8 = av; b8 = bv;
        tick();                                   // acceptance edge k
        for (int i = 1; i <= 8; i++) begin
            if (scramble) begin
                in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            end else begin
                in_valid8 = 1'b0;
            end
            tick();
            checks++;
            if (out_valid8 !== (i == 8) || in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL latency edge k+%0d out_valid=%b in_ready=%b required out_valid=%b in_ready=0",
                         i, out_valid8, in_ready8, (i == 8));
            end
        end
        out_ready8 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (out_valid8 !== 1'b1 || diff8 !== exp_d || bout8 !== exp_b) begin
                errors++;
                $display("FAIL hold cycle %0d out_valid=%b diff=%h bout=%b required 1 %h %b",
                         i, out_valid8, diff8, bout8, exp_d, exp_b);
            end
            if (scramble) begin
                in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            end
            tick();
        end
        checks++;
        if (diff8 !== exp_d || bout8 !== exp_b || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL result a=%h b=%h diff=%h bout=%b ov=%b ir=%b required %h %b ov=1 ir=0",
                     av, bv, diff8, bout8, out_valid8, in_ready8, exp_d, exp_b);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        tick();                                   // handoff edge
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL handoff out_valid=%b in_ready=%b required 0 1", out_valid8, in_ready8);
        end
        checks++;
        if (diff8 !== exp_d || bout8 !== exp_b) begin
            errors++;
            $display("FAIL retain diff=%h bout=%b required %h %b", diff8, bout8, exp_d, exp_b);
        end
        if (scramble) begin
            for (int i = 0; i < 12; i++) begin
                tick();
                checks++;
                if (out_valid8 !== 1'b0) begin
                    errors++;
                    $display("FAIL extra_result cycle %0d out_valid=%b required 0", i, out_valid8);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst4 = 1'b1;
        tick(); tick();
        rst8 = 1'b0; rst4 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8 ir=%b ov=%b diff=%h bout=%b required 1 0 00 0",
                     in_ready8, out_valid8, diff8, bout8);
        end
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || diff4 !== 4'h0 || bout4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4 ir=%b ov=%b diff=%h bout=%b required 1 0 0 0",
                     in_ready4, out_valid4, diff4, bout4);
        end
    endtask

    task automatic test_directed();
        run_op8(8'h05, 8'h03, 0, 1'b0);
        run_op8(8'h03, 8'h05, 0, 1'b0);
        run_op8(8'h00, 8'hFF, 0, 1'b0);
        run_op8(8'hA7, 8'hA7, 0, 1'b0);
        run_op8(8'hFF, 8'h00, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_op8(8'h3C, 8'h5A, 5, 1'b0);
    endtask

    task automatic test_ignore_inputs();
        run_op8(8'h81, 8'h7E, 3, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_run();
        in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        tick();                                   // accepted
        in_valid8 = 1'b0;
        tick(); tick(); tick();                   // three RUN cycles
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run ir=%b ov=%b diff=%h bout=%b required 1 0 00 0",
                     in_ready8, out_valid8, diff8, bout8);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL aborted_result cycle %0d out_valid=%b required 0", i, out_valid8);
            end
        end
        run_op8(8'h40, 8'h41, 1, 1'b0);
    endtask

    task automatic test_back_to_back4();
        int ref_d[$];
        int ref_b[$];
        int idx, got, cycles, ed, eb;
        bit fire_in, fire_out;
        idx = 0; got = 0; cycles = 0;
        in_valid4 = 1'b1; a4 = 4'd0; b4 = 4'd0; out_ready4 = 1'($urandom);
        while (got < 256 && cycles < 20000) begin
            fire_in  = in_valid4 && in_ready4;
            fire_out = out_valid4 && out_ready4;
            if (fire_out) begin
                checks++;
                if (ref_d.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected diff=%h bout=%b required no result", diff4, bout4);
                end else begin
                    ed = ref_d.pop_front();
                    eb = ref_b.pop_front();
                    if (diff4 !== 4'(ed) || bout4 !== 1'(eb)) begin
                        errors++;
                        $display("FAIL b2b result %0d diff=%h bout=%b required %h %0d",
                                 got, diff4, bout4, ed, eb);
                    end
                end
                got++;
            end
            if (fire_in) begin
                ref_d.push_back((int'(a4) - int'(b4) + 16) % 16);
                ref_b.push_back(int'(a4) < int'(b4));
                idx++;
            end
            tick();
            cycles++;
            in_valid4  = (idx < 256);
            a4         = 4'(idx / 16);
            b4         = 4'(idx % 16);
            out_ready4 = 1'($urandom);
        end
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        checks++;
        if (got != 256 || ref_d.size() != 0) begin
            errors++;
            $display("FAIL b2b_count results=%0d pending=%0d required 256 0", got, ref_d.size());
        end
    endtask

    initial begin
        rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        rst4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_directed();
        test_hold();
        test_ignore_inputs();
        test_random();
        test_reset_mid_run();
        test_back_to_back4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have port a, input, WIDTH bits: minuend, unsigned.
REQ-007 The block SHALL have port b, input, WIDTH bits: subtrahend, unsigned.
REQ-008 The block SHALL have port out_valid, output, 1 bit: diff/bout hold a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: (a - b) mod 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: final borrow, 1 iff a < b (unsigned).

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-014 In IDLE, when in_valid and in_ready are both high, the block SHALL capture a and b into shift registers, clear the borrow register and the bit counter, and enter RUN.
REQ-015 In each RUN cycle, the block SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 In each RUN cycle, the block SHALL shift d into the MSB of the result register, shift both operand registers right by one bit, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the cycle where the counter equals WIDTH-1, the next state SHALL be DONE.
REQ-018 Latency SHALL be fixed: for operands accepted at edge k, out_valid SHALL be high after edge k+WIDTH.
REQ-019 In DONE, diff and bout SHALL be held stable until out_valid and out_ready are both high; the block SHALL then return to IDLE.
REQ-020 The block SHALL NOT accept new operands in the same cycle as result handoff; in_ready SHALL rise on the cycle after handoff.
REQ-021 in_valid, a and b SHALL be ignored in RUN and DONE; out_ready SHALL be ignored in IDLE and RUN.
REQ-022 diff and bout SHALL retain the last result after handoff, until the next load.
REQ-023 Boundary: a == b SHALL give diff 0 and bout 0; a = 0 with b = 2^WIDTH-1 SHALL give diff 1 and bout 1 (wrap-around).

Reset
REQ-024 While rst is high at a clock edge, the block SHALL set state to IDLE, diff to 0, bout to 0, the borrow register to 0 and the counter to 0, so that in_ready = 1 and out_valid = 0 afterwards.
REQ-025 Reset SHALL override every other event, including mid-RUN and an in-progress DONE handshake; an aborted operation SHALL produce no result.

Structure
REQ-026 A shared package serial_arith_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 Per-bit arithmetic SHALL be a combinational sub-module full_subtractor (ports a, b, bin, diff, bout), instantiated once.
REQ-028 The counter width SHALL be $clog2(WIDTH) bits.

Verification
REQ-029 With WIDTH=8, a=8'h05 and b=8'h03 -> diff=8'h02, bout=0, with out_valid high exactly 8 cycles after acceptance.
REQ-030 With a=8'h03 and b=8'h05 -> diff=8'hFE, bout=1; with a=8'h00 and b=8'hFF -> diff=8'h01, bout=1.
REQ-031 With out_ready held low for 5 cycles in DONE -> diff/bout stable and out_valid high throughout; in_ready rises the cycle after handoff.
REQ-032 With in_valid toggled and a/b changed during RUN -> result unaffected, and only one result produced.
REQ-033 With rst pulsed at RUN cycle 3 -> next cycle in_ready=1, out_valid=0, diff=0, bout=0, and a following operation computes correctly.
REQ-034 With WIDTH=4, all 256 operand pairs sent back-to-back with random out_ready -> every diff/bout matches a reference model.
